// File: rtl/zoom_pkg.sv
// Shared widths and presets for the ZOOM downscaler coefficient path.
package zoom_pkg;

  localparam int ZOOM_COORD_W = 12;
  localparam int ZOOM_FRAC_W  = 5;
  localparam int ZOOM_STEP_IW = 4;
  localparam int ZOOM_COEF_W  = 4;

  localparam int ZOOM_STEP_W  = ZOOM_STEP_IW + ZOOM_FRAC_W;
  localparam int ZOOM_OFS_W   = ZOOM_COORD_W + ZOOM_FRAC_W;

  // Step of exactly 1.0 in the default fixed-point format.
  localparam logic [ZOOM_STEP_W-1:0] ZOOM_STEP_ONE = ZOOM_STEP_W'(1) << ZOOM_FRAC_W;

  // 1280 -> 720: 1280/720 * 32 = 56.9, centred first sample at (step-1)/2.
  localparam logic [ZOOM_STEP_W-1:0] ZOOM_STEP_1280_720 = ZOOM_STEP_W'(57);
  localparam logic [ZOOM_OFS_W-1:0]  ZOOM_OFS_1280_720  = ZOOM_OFS_W'(12);

endpackage

// File: rtl/zoom_coef_gen_axis.sv
// zoom_axis_dda: one axis of the destination sampling grid (counter, position, hit, weight).
module zoom_axis_dda
  import zoom_pkg::*;
#(
  parameter int COORD_W = ZOOM_COORD_W,
  parameter int FRAC_W  = ZOOM_FRAC_W,
  parameter int STEP_IW = ZOOM_STEP_IW,
  parameter int COEF_W  = ZOOM_COEF_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       adv,
  input  logic                       en,
  input  logic [STEP_IW+FRAC_W-1:0]  step,
  input  logic [COORD_W+FRAC_W-1:0]  ofs,
  output logic                       hit,
  output logic [COEF_W-1:0]          coef
);

  localparam int SW = STEP_IW + FRAC_W;
  localparam int PW = COORD_W + 1 + FRAC_W;
  localparam logic [SW-1:0] STEP_UNIT = SW'(1) << FRAC_W;

  logic [COORD_W-1:0] cnt;
  logic [PW-1:0]      pos;
  logic [SW-1:0]      step_eff;
  logic [COORD_W-1:0] pos_int;
  logic               pos_ovf;

  // Sub-unity steps would allow several hits per pixel; clamp them to 1.0.
  assign step_eff = (step[SW-1:FRAC_W] == '0) ? STEP_UNIT : step;
  assign pos_ovf  = pos[PW-1];
  assign pos_int  = pos[PW-2:FRAC_W];
  assign hit      = en & (pos_int == cnt) & ~pos_ovf;
  assign coef     = pos[FRAC_W-1 -: COEF_W];

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
      pos <= {1'b0, ofs};
    end else if (adv) begin
      if (cnt != '1)
        cnt <= cnt + 1'b1;
      if (hit)
        pos <= pos + PW'(step_eff);
    end
  end

endmodule

// File: rtl/zoom_coef_gen.sv
// Source-side coefficient generator: per-pixel hit flag and bilinear weights.
// Optional dx*dy product pipeline enabled by defining ZOOM_COEF_DXY_EN.
module zoom_coef_gen
  import zoom_pkg::*;
#(
  parameter int COORD_W = ZOOM_COORD_W,
  parameter int FRAC_W  = ZOOM_FRAC_W,
  parameter int STEP_IW = ZOOM_STEP_IW,
  parameter int COEF_W  = ZOOM_COEF_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vs,
  input  logic                       vld,
  input  logic                       hs_end,
  input  logic [STEP_IW+FRAC_W-1:0]  step_x,
  input  logic [STEP_IW+FRAC_W-1:0]  step_y,
  input  logic [COORD_W+FRAC_W-1:0]  ofs_x,
  input  logic [COORD_W+FRAC_W-1:0]  ofs_y,
  output logic [COEF_W-1:0]          dx,
  output logic [COEF_W-1:0]          dy,
  output logic                       xy_vld,
  output logic [2*COEF_W-1:0]        dxy,
  output logic                       dxy_vld
);

  logic              hit_x, hit_y;
  logic [COEF_W-1:0] coef_x, coef_y;
  logic              pix;
  logic              xy_hit;

  // vs outranks the pixel; hs_end does not, the pixel sees pre-reload state.
  assign pix    = vld & ~vs;
  assign xy_hit = hit_x & hit_y;

  zoom_axis_dda #(
    .COORD_W(COORD_W), .FRAC_W(FRAC_W), .STEP_IW(STEP_IW), .COEF_W(COEF_W)
  ) u_axis_x (
    .clk (clk),
    .rst (rst),
    .load(vs | hs_end),
    .adv (pix),
    .en  (pix),
    .step(step_x),
    .ofs (ofs_x),
    .hit (hit_x),
    .coef(coef_x)
  );

  zoom_axis_dda #(
    .COORD_W(COORD_W), .FRAC_W(FRAC_W), .STEP_IW(STEP_IW), .COEF_W(COEF_W)
  ) u_axis_y (
    .clk (clk),
    .rst (rst),
    .load(vs),
    .adv (hs_end & ~vs),
    .en  (1'b1),
    .step(step_y),
    .ofs (ofs_y),
    .hit (hit_y),
    .coef(coef_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      xy_vld <= 1'b0;
      dx     <= '0;
      dy     <= '0;
    end else begin
      xy_vld <= xy_hit;
      if (xy_hit) begin
        dx <= coef_x;
        dy <= coef_y;
      end
    end
  end

`ifdef ZOOM_COEF_DXY_EN
  logic [2*COEF_W-1:0] prod;
  logic                prod_vld;
  logic [2*COEF_W-1:0] dx_ext, dy_ext;

  assign dx_ext = {{COEF_W{1'b0}}, dx};
  assign dy_ext = {{COEF_W{1'b0}}, dy};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      dxy      <= '0;
      dxy_vld  <= 1'b0;
    end else begin
      prod     <= dx_ext * dy_ext;
      prod_vld <= xy_vld;
      dxy      <= prod;
      dxy_vld  <= prod_vld;
    end
  end
`else
  assign dxy     = '0;
  assign dxy_vld = 1'b0;
`endif

endmodule
